// File: rtl/seven_seg_scan_display_if.sv
// Display-word handshake: a producer offers a word and mode, the scanner accepts
// it into its shadow register when in_rdy is high.
interface seven_seg_scan_display_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    in_val;
   logic                    in_rdy;
   logic [4*NUM_DIGITS-1:0] in_data;
   logic                    in_mode;

   modport master (output in_val, in_data, in_mode, input in_rdy);
   modport slave  (input in_val, in_data, in_mode, output in_rdy);
endinterface

// File: rtl/seven_seg_scan_display.sv
// Multiplexed seven-segment scanner with double-buffered display word; new words
// land in a shadow register and become visible only at a frame boundary.
module seven_seg_scan_display #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   seven_seg_scan_display_if.slave in_bus,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_done
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CW-1:0]                r_div;
   logic [IW-1:0]                r_idx;
   logic [NUM_DIGITS-1:0][3:0]   r_act_word;
   logic                         r_act_mode;
   logic [NUM_DIGITS-1:0][3:0]   r_sh_word;
   logic                         r_sh_mode;
   logic                         r_pend;
   logic [6:0]                   r_seg;
   logic [NUM_DIGITS-1:0]        r_den;

   logic                         w_div_wrap;
   logic                         w_frame;
   logic                         w_accept;
   logic [3:0]                   w_nib;
   logic [IW-1:0]                w_msnz;
   logic                         w_blank;
   logic [6:0]                   w_seg_nxt;
   logic [NUM_DIGITS-1:0]        w_den_nxt;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h18;
         4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
      endcase
   endfunction

   assign w_div_wrap = (r_div == CW'(REFRESH_DIV - 1));
   assign w_frame    = w_div_wrap && (r_idx == IW'(NUM_DIGITS - 1));
   assign w_accept   = in_bus.in_val && in_bus.in_rdy;

   // Reset gates the combinational outputs so they are quiet from the first reset cycle.
   assign in_bus.in_rdy = !r_pend && !rst;
   assign frame_done    = w_frame && !rst;
   assign seg           = r_seg;
   assign digit_en      = r_den;

   always_comb begin
      w_msnz = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (r_act_word[k] != 4'h0) w_msnz = IW'(k);
   end

   assign w_nib     = r_act_word[r_idx];
   assign w_blank   = r_act_mode && (r_idx > w_msnz);
   assign w_seg_nxt = w_blank                        ? 7'h7F :
                      (r_act_mode && (w_nib > 4'd9)) ? 7'h3F : hex_seg(w_nib);
   assign w_den_nxt = ~(NUM_DIGITS'(1) << r_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div      <= '0;
         r_idx      <= '0;
         r_act_word <= '0;
         r_act_mode <= 1'b0;
         r_sh_word  <= '0;
         r_sh_mode  <= 1'b0;
         r_pend     <= 1'b0;
         r_seg      <= 7'h7F;
         r_den      <= '1;
      end else begin
         r_div <= w_div_wrap ? '0 : r_div + CW'(1);
         if (w_div_wrap)
            r_idx <= w_frame ? '0 : r_idx + IW'(1);
         // Copy and accept are exclusive: accept needs pending clear, copy needs it set.
         if (w_frame && r_pend) begin
            r_act_word <= r_sh_word;
            r_act_mode <= r_sh_mode;
            r_pend     <= 1'b0;
         end
         if (w_accept) begin
            r_sh_word <= in_bus.in_data;
            r_sh_mode <= in_bus.in_mode;
            r_pend    <= 1'b1;
         end
         r_seg <= w_seg_nxt;
         r_den <= w_den_nxt;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Randomized and directed bench for seven_seg_scan_display with a cycle-count
// based reference model of scan position, shadow/active words and digit rendering.
module tb_seven_seg_scan_display;
   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int FRAME = ND * RD;
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic          clk;
   logic          rst;
   logic [6:0]    seg;
   logic [ND-1:0] digit_en;
   logic          frame_done;

   seven_seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .in_bus(bus),
      .seg(seg), .digit_en(digit_en), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position derives from cycles since reset.
   function automatic logic [6:0] disp(input logic [15:0] w, input logic m, input int k);
      int top;
      logic [3:0] n;
      top = 0;
      for (int j = 0; j < ND; j++)
         if (((w >> (4 * j)) & 16'hF) != 16'h0) top = j;
      n = 4'((w >> (4 * k)) & 16'hF);
      if (m && k > top) return 7'h7F;
      if (m && n > 4'd9) return 7'h3F;
      return HEX[n];
   endfunction

   int          m_n = 0;
   logic [15:0] m_act, m_sh;
   logic        m_am, m_shm, m_pend;
   logic [6:0]  e_seg;
   logic [3:0]  e_den;
   bit          m_valid = 0;

   always @(posedge clk) begin
      int idx;
      if (rst) begin
         m_n = 0; m_act = 16'h0; m_am = 1'b0; m_pend = 1'b0;
         e_seg = 7'h7F; e_den = 4'hF; m_valid = 1;
      end else if (m_valid) begin
         idx   = (m_n / RD) % ND;
         e_seg = disp(m_act, m_am, idx);
         e_den = ~(4'b0001 << idx);
         if ((m_n % FRAME) == FRAME - 1 && m_pend) begin
            m_act = m_sh; m_am = m_shm; m_pend = 1'b0;
         end else if (bus.in_val && !m_pend) begin
            m_sh = bus.in_data; m_shm = bus.in_mode; m_pend = 1'b1;
         end
         m_n++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_seg", 32'(seg), 32'(e_seg));
         chk("model_den", 32'(digit_en), 32'(e_den));
         chk("model_rdy", 32'(bus.in_rdy), 32'(!rst && !m_pend));
         chk("model_fd", 32'(frame_done), 32'(!rst && ((m_n % FRAME) == FRAME - 1)));
      end
   end

   logic [6:0] got [ND];

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic wait_fd(input int budget);
      int i;
      i = 0;
      @(negedge clk);
      while (!frame_done && i < budget) begin @(negedge clk); i++; end
      if (!frame_done) begin
         checks++; fails++;
         $display("FAIL wait_frame_done got=timeout expected=pulse t=%0t", $time);
      end
   endtask

   task automatic collect();
      logic [3:0] m;
      for (int k = 0; k < ND; k++) got[k] = 7'h55;
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         for (int k = 0; k < ND; k++) begin
            m = 4'b0001 << k;
            if (digit_en == ~m) got[k] = seg;
         end
      end
   endtask

   task automatic load(input logic [15:0] w, input logic md);
      int i;
      i = 0;
      while (!bus.in_rdy && i < 4 * FRAME) begin step(); i++; end
      chk("load_rdy", 32'(bus.in_rdy), 32'd1);
      bus.in_val = 1'b1; bus.in_data = w; bus.in_mode = md;
      step();
      bus.in_val = 1'b0;
   endtask

   task automatic show(input logic [15:0] w, input logic md, input logic [6:0] e0,
                       input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3);
      load(w, md);
      wait_fd(3 * FRAME);
      chk("rdy_low_in_wrap", 32'(bus.in_rdy), 32'd0);
      @(negedge clk);
      chk("rdy_after_wrap", 32'(bus.in_rdy), 32'd1);
      @(posedge clk);
      collect();
      chk("show_d0", 32'(got[0]), 32'(e0));
      chk("show_d1", 32'(got[1]), 32'(e1));
      chk("show_d2", 32'(got[2]), 32'(e2));
      chk("show_d3", 32'(got[3]), 32'(e3));
   endtask

   initial begin
      int gap;
      rst = 1'b1; bus.in_val = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_den", 32'(digit_en), 32'hF);
      chk("rst_rdy", 32'(bus.in_rdy), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);

      step(); rst = 1'b0;
      @(negedge clk);
      chk("rdy_first_cycle", 32'(bus.in_rdy), 32'd1);
      for (int i = 0; i < RD; i++) begin
         @(negedge clk);
         chk("post_rst_den0", 32'(digit_en), 32'hE);
         chk("post_rst_seg0", 32'(seg), 32'h40);
      end
      @(negedge clk);
      chk("post_rst_den1", 32'(digit_en), 32'hD);

      wait_fd(2 * FRAME);
      gap = 0;
      @(negedge clk); gap++;
      while (!frame_done && gap < 4 * FRAME) begin @(negedge clk); gap++; end
      chk("frame_period", 32'(gap), 32'(FRAME));

      @(posedge clk); #2;
      show(16'h1A2F, 1'b0, 7'h0E, 7'h24, 7'h08, 7'h79);
      show(16'h0090, 1'b1, 7'h40, 7'h18, 7'h7F, 7'h7F);
      show(16'h0000, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F);
      show(16'h00C5, 1'b1, 7'h12, 7'h3F, 7'h7F, 7'h7F);

      // Back-to-back words with in_val held high.
      step();
      load(16'h1234, 1'b0);
      bus.in_val = 1'b1; bus.in_data = 16'h5678;
      wait_fd(3 * FRAME);
      chk("b2b_rdy_wrap", 32'(bus.in_rdy), 32'd0);
      step();
      chk("b2b_rdy_after", 32'(bus.in_rdy), 32'd1);
      step();
      bus.in_val = 1'b0;
      @(negedge clk);
      chk("b2b_second_pending", 32'(bus.in_rdy), 32'd0);

      // Offer a word exactly in the wrap cycle.
      wait_fd(3 * FRAME);
      @(negedge clk);
      wait_fd(3 * FRAME);
      chk("wrap_offer_rdy", 32'(bus.in_rdy), 32'd1);
      bus.in_val = 1'b1; bus.in_data = 16'h0042; bus.in_mode = 1'b1;
      @(posedge clk); #2;
      bus.in_val = 1'b0;
      repeat (2 * FRAME + 2) step();

      // Reset mid-frame while a word is pending.
      load(16'h8888, 1'b0);
      step();
      rst = 1'b1;
      step(); step();
      @(negedge clk);
      chk("midrst_seg", 32'(seg), 32'h7F);
      chk("midrst_den", 32'(digit_en), 32'hF);
      chk("midrst_rdy", 32'(bus.in_rdy), 32'd0);
      chk("midrst_fd", 32'(frame_done), 32'd0);
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk);
      collect();
      for (int k = 0; k < ND; k++) chk("midrst_clean", 32'(got[k]), 32'h40);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.in_val  = ($urandom % 3) == 0;
         bus.in_data = 16'($urandom);
         bus.in_mode = 1'($urandom % 2);
         rst         = ($urandom % 400) == 0;
      end
      step();
      rst = 1'b0; bus.in_val = 1'b0;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
